// File: rtl/clkdiv_tick_sched.sv
// rtl/clkdiv_tick_sched.sv - divider-tap edge detector with round-robin tick event scheduler
module clkdiv_tick_sched #(
    parameter int N_CH = 4,
    parameter int CHW  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     clkdiv,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [CHW-1:0]  cfg_ch,
    input  logic [4:0]      cfg_tap,
    input  logic            cfg_en,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [CHW-1:0]  evt_ch,
    output logic [N_CH-1:0] ovf,
    input  logic            ovf_clr
);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t          state, state_nx;
    logic [4:0]      tap [N_CH];
    logic [N_CH-1:0] en, prev, pend;
    logic [N_CH-1:0] cur, rise, cfg_hit, hs, ovr;
    logic [CHW-1:0]  ptr, ptr_nx, evt_ch_nx, pick;
    logic            pick_found;
    int              idx;

    // Configuration is never back-pressured; it is only refused while in reset.
    assign cfg_ready = ~rst;
    assign evt_valid = (state == OFFER);

    // Per-channel tap selection, rising-edge detect, config hit, handshake and overrun.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            cur[i]     = clkdiv[tap[i]];
            rise[i]    = en[i] & cur[i] & ~prev[i];
            cfg_hit[i] = cfg_valid & (cfg_ch == CHW'(i));
            hs[i]      = (state == OFFER) & evt_ready & (evt_ch == CHW'(i));
            ovr[i]     = rise[i] & pend[i] & ~hs[i];
        end
    end

    // Channel state: config write beats a new rise, which beats a completed handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                tap[i] <= '0;
            end
            en   <= '0;
            prev <= '0;
            pend <= '0;
            ovf  <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (cfg_hit[i]) begin
                    tap[i]  <= cfg_tap;
                    en[i]   <= cfg_en;
                    prev[i] <= clkdiv[cfg_tap];
                    pend[i] <= 1'b0;
                end else begin
                    prev[i] <= cur[i];
                    if (rise[i]) begin
                        pend[i] <= 1'b1;
                    end else if (hs[i]) begin
                        pend[i] <= 1'b0;
                    end
                end
            end
            // A fresh overrun in the clearing cycle still sets its bit.
            ovf <= (ovf & ~{N_CH{ovf_clr}}) | ovr;
        end
    end

    // Cyclic search for the first pending channel at or after the round-robin pointer.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        idx        = 0;
        for (int k = 0; k < N_CH; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            if (!pick_found && pend[CHW'(idx)]) begin
                pick_found = 1'b1;
                pick       = CHW'(idx);
            end
        end
    end

    // Arbiter next state: latch a winner in IDLE, hold it stable while offering.
    always_comb begin
        state_nx  = state;
        evt_ch_nx = evt_ch;
        ptr_nx    = ptr;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    evt_ch_nx = pick;
                    state_nx  = OFFER;
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    if (int'(evt_ch) == N_CH - 1) begin
                        ptr_nx = '0;
                    end else begin
                        ptr_nx = evt_ch + 1'b1;
                    end
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Arbiter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            evt_ch <= '0;
            ptr    <= '0;
        end else begin
            state  <= state_nx;
            evt_ch <= evt_ch_nx;
            ptr    <= ptr_nx;
        end
    end

endmodule
